// File: rtl/bcd_serial_addsub_pkg.sv
// Shared types and helpers for the serial packed-BCD add/subtract datapath.
package bcd_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } bcd_seq_state_t;

  function automatic logic is_bcd(input bcd_digit_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_serial_addsub_if.sv
// Request/response bundle between a sequencer and the serial BCD add/subtract unit.
interface bcd_serial_addsub_if #(
  parameter int DIGITS = 4
) ();
  import bcd_pkg::*;

  logic                        start;
  logic                        sub;
  logic                        carry_in;
  logic [DIGIT_W*DIGITS-1:0]   a;
  logic [DIGIT_W*DIGITS-1:0]   b;
  logic                        busy;
  logic                        done;
  logic [DIGIT_W*DIGITS-1:0]   result;
  logic                        carry_out;
  logic                        error;

  modport master (
    output start, sub, carry_in, a, b,
    input  busy, done, result, carry_out, error
  );

  modport slave (
    input  start, sub, carry_in, a, b,
    output busy, done, result, carry_out, error
  );

endinterface

// File: rtl/bcd_serial_addsub_digit.sv
// One decimal digit of add/subtract: nine's-complement select on b, then +6 decimal correction.
module bcd_digit_addsub
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       sub,
  input  logic       cin,
  output bcd_digit_t digit,
  output logic       cout
);

  bcd_digit_t bEff;
  logic [4:0] rawSum;

  // Raw binary digit sum (max 19) folded back into a single BCD digit plus decimal carry
  always_comb begin
    bEff   = sub ? (BCD_MAX - b) : b;
    rawSum = {1'b0, a} + {1'b0, bEff} + {4'b0000, cin};
    if (rawSum > {1'b0, BCD_MAX}) begin
      digit = rawSum[3:0] + 4'd6;
      cout  = 1'b1;
    end else begin
      digit = rawSum[3:0];
      cout  = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Multi-digit packed-BCD adder/subtractor, one digit per clock LSD first, with start/busy/done handshake.
module bcd_serial_addsub
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  bcd_serial_addsub_if.slave bus
);

  localparam int W    = DIGIT_W * DIGITS;
  localparam int IDXW = $clog2(DIGITS + 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

  bcd_seq_state_t  state;
  logic [IDXW-1:0] idx;
  logic [W-1:0]    opA;
  logic [W-1:0]    opB;
  logic            subR;
  logic            carry;
  logic [W-1:0]    resultR;
  logic            carryOutR;
  logic            errorR;
  logic            busyR;
  logic            doneR;
  logic            anyInvalid;
  bcd_digit_t      digitSum;
  logic            digitCarry;

  // Flag any non-BCD nibble in either live operand
  always_comb begin
    anyInvalid = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      anyInvalid = anyInvalid
                 | ~is_bcd(bus.a[i*DIGIT_W +: DIGIT_W])
                 | ~is_bcd(bus.b[i*DIGIT_W +: DIGIT_W]);
    end
  end

  // Operands shift right each RUN cycle, so the active digit is always the low nibble
  bcd_digit_addsub uDigit (
    .a     (opA[DIGIT_W-1:0]),
    .b     (opB[DIGIT_W-1:0]),
    .sub   (subR),
    .cin   (carry),
    .digit (digitSum),
    .cout  (digitCarry)
  );

  // Sequencer FSM with all handshake and result outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      opA       <= '0;
      opB       <= '0;
      subR      <= 1'b0;
      carry     <= 1'b0;
      resultR   <= '0;
      carryOutR <= 1'b0;
      errorR    <= 1'b0;
      busyR     <= 1'b0;
      doneR     <= 1'b0;
    end else begin
      doneR <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            opA       <= bus.a;
            opB       <= bus.b;
            subR      <= bus.sub;
            // Subtract runs as a + nines(b) + ~borrow, so the borrow-in is inverted here
            carry     <= bus.sub ? ~bus.carry_in : bus.carry_in;
            idx       <= '0;
            resultR   <= '0;
            carryOutR <= 1'b0;
            errorR    <= anyInvalid;
            busyR     <= ~anyInvalid;
            state     <= anyInvalid ? FIN : RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          resultR[int'(idx)*DIGIT_W +: DIGIT_W] <= digitSum;
          carry <= digitCarry;
          opA   <= opA >> DIGIT_W;
          opB   <= opB >> DIGIT_W;
          idx   <= idx + IDXW'(1);
          if (idx == LAST_IDX) begin
            busyR <= 1'b0;
            state <= FIN;
          end else begin
            state <= RUN;
          end
        end
        FIN: begin
          doneR     <= 1'b1;
          carryOutR <= errorR ? 1'b0 : (subR ? ~carry : carry);
          state     <= IDLE;
        end
        default: begin
          busyR <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busyR;
  assign bus.done      = doneR;
  assign bus.result    = resultR;
  assign bus.carry_out = carryOutR;
  assign bus.error     = errorR;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Self-checking bench: directed vector table, reset/start corner sequences, and randomized ops vs a decimal integer model.
module tb_bcd_serial_addsub;

  logic clk = 1'b0;
  logic reset;
  int   nCmp = 0;
  int   nBad = 0;
  int   dc1 = 0, dc4 = 0, dc7 = 0;

  always #5 clk = ~clk;

  bcd_serial_addsub_if #(.DIGITS(1)) if1 ();
  bcd_serial_addsub_if #(.DIGITS(4)) if4 ();
  bcd_serial_addsub_if #(.DIGITS(7)) if7 ();

  bcd_serial_addsub #(.DIGITS(1)) u1 (.clk(clk), .reset(reset), .bus(if1));
  bcd_serial_addsub #(.DIGITS(4)) u4 (.clk(clk), .reset(reset), .bus(if4));
  bcd_serial_addsub #(.DIGITS(7)) u7 (.clk(clk), .reset(reset), .bus(if7));

  always @(negedge clk) begin
    if (if1.done === 1'b1) dc1++;
    if (if4.done === 1'b1) dc4++;
    if (if7.done === 1'b1) dc7++;
  end

  typedef struct {
    string       name;
    logic        sb;
    logic        ci;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        co;
    logic        er;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic setIn(input int sel, input logic st, input logic sb, input logic ci,
                       input logic [27:0] av, input logic [27:0] bv);
    case (sel)
      1: begin if1.start = st; if1.sub = sb; if1.carry_in = ci; if1.a = av[3:0];  if1.b = bv[3:0];  end
      4: begin if4.start = st; if4.sub = sb; if4.carry_in = ci; if4.a = av[15:0]; if4.b = bv[15:0]; end
      default: begin if7.start = st; if7.sub = sb; if7.carry_in = ci; if7.a = av; if7.b = bv; end
    endcase
  endtask

  task automatic getOut(input int sel, output logic bz, output logic dn, output logic co,
                        output logic er, output logic [27:0] res);
    case (sel)
      1: begin bz = if1.busy; dn = if1.done; co = if1.carry_out; er = if1.error; res = {24'd0, if1.result}; end
      4: begin bz = if4.busy; dn = if4.done; co = if4.carry_out; er = if4.error; res = {12'd0, if4.result}; end
      default: begin bz = if7.busy; dn = if7.done; co = if7.carry_out; er = if7.error; res = if7.result; end
    endcase
  endtask

  // Decimal reference: convert to integers, do plain arithmetic, convert back
  task automatic model(input int nd, input logic sb, input logic ci, input logic [27:0] av,
                       input logic [27:0] bv, output logic [27:0] res, output logic co, output logic er);
    longint va = 0, vb = 0, md = 1, p = 1, r;
    er = 1'b0;
    for (int i = 0; i < nd; i++) begin
      if (av[4*i +: 4] > 4'd9 || bv[4*i +: 4] > 4'd9) er = 1'b1;
      va += longint'(av[4*i +: 4]) * p;
      vb += longint'(bv[4*i +: 4]) * p;
      p  *= 10;
      md *= 10;
    end
    res = '0;
    co  = 1'b0;
    if (!er) begin
      if (!sb) begin
        r  = va + vb + longint'(ci);
        co = (r >= md);
        r  = r % md;
      end else begin
        r  = va - vb - longint'(ci);
        co = (r < 0);
        if (r < 0) r += md;
      end
      for (int i = 0; i < nd; i++) begin
        res[4*i +: 4] = 4'(r % 10);
        r = r / 10;
      end
    end
  endtask

  function automatic logic [27:0] randBcd(input int nd);
    logic [27:0] v = '0;
    for (int i = 0; i < nd; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // Issue one op starting at a negedge with the DUT idle; returns at the negedge where done is seen
  task automatic doOp(input int sel, input string tag, input logic sb, input logic ci,
                      input logic [27:0] av, input logic [27:0] bv,
                      input logic [27:0] eRes, input logic eCo, input logic eErr);
    logic bz, dn, co, er;
    logic [27:0] res;
    int k = 0, busyCnt = 0;
    bit got = 1'b0;
    setIn(sel, 1'b1, sb, ci, av, bv);
    @(posedge clk);
    while (!got && k < 40) begin
      @(negedge clk);
      k++;
      getOut(sel, bz, dn, co, er, res);
      if (bz === 1'b1) busyCnt++;
      if (dn === 1'b1) got = 1'b1;
      if (k == 1) setIn(sel, 1'b0, 1'($urandom), 1'($urandom), 28'($urandom), 28'($urandom));
    end
    check({tag, " done"}, 32'(got), 32'd1);
    check({tag, " latency"}, 32'(k), eErr ? 32'd2 : 32'(sel + 2));
    check({tag, " busy"}, 32'(busyCnt), eErr ? 32'd0 : 32'(sel));
    check({tag, " result"}, {4'd0, res}, {4'd0, eRes});
    check({tag, " carry_out"}, {31'd0, co}, {31'd0, eCo});
    check({tag, " error"}, {31'd0, er}, {31'd0, eErr});
  endtask

  task automatic randOp(input int sel, input bit inject);
    logic sb, ci, eCo, eErr;
    logic [27:0] av, bv, eRes;
    sb = 1'($urandom_range(0, 1));
    ci = 1'($urandom_range(0, 1));
    av = randBcd(sel);
    bv = randBcd(sel);
    if (inject && $urandom_range(0, 15) == 0) begin
      if ($urandom_range(0, 1) == 0) av[4*$urandom_range(0, sel-1) +: 4] = 4'($urandom_range(10, 15));
      else                           bv[4*$urandom_range(0, sel-1) +: 4] = 4'($urandom_range(10, 15));
    end
    model(sel, sb, ci, av, bv, eRes, eCo, eErr);
    doOp(sel, "rand", sb, ci, av, bv, eRes, eCo, eErr);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, ops;
    logic bz, dn, co, er, eCo, eErr;
    logic [27:0] res, eRes;

    vecs[0] = '{"add 1234+5678",   1'b0, 1'b0, 16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0};
    vecs[1] = '{"add 9999+0001",   1'b0, 1'b0, 16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{"add 0+0 cin",     1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0001, 1'b0, 1'b0};
    vecs[3] = '{"add 5555+4444 c", 1'b0, 1'b1, 16'h5555, 16'h4444, 16'h0000, 1'b1, 1'b0};
    vecs[4] = '{"sub 5000-0001",   1'b1, 1'b0, 16'h5000, 16'h0001, 16'h4999, 1'b0, 1'b0};
    vecs[5] = '{"sub 0000-0001",   1'b1, 1'b0, 16'h0000, 16'h0001, 16'h9999, 1'b1, 1'b0};
    vecs[6] = '{"sub 0100-0099 c", 1'b1, 1'b1, 16'h0100, 16'h0099, 16'h0000, 1'b0, 1'b0};
    vecs[7] = '{"sub 9999-9999 c", 1'b1, 1'b1, 16'h9999, 16'h9999, 16'h9999, 1'b1, 1'b0};
    vecs[8] = '{"bad a 12A4",      1'b0, 1'b0, 16'h12A4, 16'h0000, 16'h0000, 1'b0, 1'b1};
    vecs[9] = '{"bad b F000 sub",  1'b1, 1'b1, 16'h0123, 16'hF000, 16'h0000, 1'b0, 1'b1};

    for (int s = 1; s <= 7; s += 3) setIn(s, 1'b0, 1'b0, 1'b0, 28'd0, 28'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 1; s <= 7; s += 3) begin
      getOut(s, bz, dn, co, er, res);
      check("reset outputs", {res, bz, dn, co, er}, 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i])
      doOp(4, vecs[i].name, vecs[i].sb, vecs[i].ci, 28'(vecs[i].a), 28'(vecs[i].b),
           28'(vecs[i].res), vecs[i].co, vecs[i].er);

    // Results hold after done while idle
    doOp(4, "add 0417+0385", 1'b0, 1'b0, 28'h0417, 28'h0385, 28'h0802, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("hold result", 32'(if4.result), 32'h0802);
    check("hold done low", 32'(if4.done), 32'd0);

    // Reset in the second RUN cycle aborts with everything cleared and no done
    d0 = dc4;
    setIn(4, 1'b1, 1'b0, 1'b0, 28'h1234, 28'h5678);
    @(posedge clk);
    @(negedge clk) setIn(4, 1'b0, 1'b0, 1'b0, 28'h1234, 28'h5678);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    getOut(4, bz, dn, co, er, res);
    check("abort outputs", {res, bz, dn, co, er}, 32'd0);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("abort no done", 32'(dc4 - d0), 32'd0);

    // A second start during RUN is ignored
    d0 = dc4;
    setIn(4, 1'b1, 1'b0, 1'b0, 28'h1234, 28'h5678);
    @(posedge clk);
    @(negedge clk) setIn(4, 1'b0, 1'b0, 1'b0, 28'h1234, 28'h5678);
    @(negedge clk) setIn(4, 1'b1, 1'b1, 1'b1, 28'h9999, 28'h0001);
    @(negedge clk) setIn(4, 1'b0, 1'b0, 1'b0, 28'h0, 28'h0);
    repeat (12) @(negedge clk);
    check("start in RUN done count", 32'(dc4 - d0), 32'd1);
    check("start in RUN result", 32'(if4.result), 32'h6912);

    // Exhaustive single-digit sweep, back to back
    d0 = dc1;
    ops = 0;
    for (int sb = 0; sb < 2; sb++)
      for (int ci = 0; ci < 2; ci++)
        for (int x = 0; x < 10; x++)
          for (int y = 0; y < 10; y++) begin
            model(1, 1'(sb), 1'(ci), 28'(x), 28'(y), eRes, eCo, eErr);
            doOp(1, "sweep1", 1'(sb), 1'(ci), 28'(x), 28'(y), eRes, eCo, eErr);
            ops++;
          end
    @(negedge clk);
    check("sweep1 done count", 32'(dc1 - d0), 32'(ops));

    d0 = dc4;
    for (int n = 0; n < 1000; n++) randOp(4, 1'b0);
    @(negedge clk);
    check("rand4 done count", 32'(dc4 - d0), 32'd1000);

    d0 = dc7;
    for (int n = 0; n < 1000; n++) randOp(7, 1'b1);
    @(negedge clk);
    check("rand7 done count", 32'(dc7 - d0), 32'd1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
